// File: rtl/gate_arb_pkg.sv
// Shared types for the gate-op arbiter: opcode encoding, FSM states and counter width.
package gate_arb_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4
  } gate_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OP_CNT_W = 8;

endpackage

// File: rtl/gate_logic_unit.sv
// Combinational WIDTH-bit bitwise logic unit; opcodes outside gate_op_t flag illegal and yield zero.
module gate_logic_unit
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gate_op_t         op,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_logic_unit among NREQ requesters;
// each request runs accept (IDLE) -> evaluate (EXEC) -> hold response (RESP).
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [OP_CNT_W-1:0]   op_count
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   cur_id;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   idx_c;
  logic             grant_found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             accept;

  // Operand registers hold data only; they are qualified by state, so no reset.
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] y_p1;
  logic             ill_p1;

  // Search starts just past the last winner so it has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_c       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_c = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[idx_c]) begin
        grant_found = 1'b1;
        grant_id    = idx_c;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept && !reset) req_ready[grant_id] = 1'b1;
  end

  // Stage p0: capture the winner's operands on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      op_p0 <= sel_op;
    end
  end

  gate_logic_unit #(.WIDTH(WIDTH)) u_glu (
    .a       (a_p0),
    .b       (b_p0),
    .op      (gate_op_t'(op_p0)),
    .y       (y_p1),
    .illegal (ill_p1)
  );

  // Stage p1: register the unit's result into the held response.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) cur_id <= grant_id;
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_data  <= ill_p1 ? '0 : y_p1;
        rsp_err   <= ill_p1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
        last_grant <= cur_id;
        op_count   <= op_count + 1'b1;
      end
    end
  end

endmodule
